// File: rtl/calc_mmio_pkg.sv
// Shared types and constants for the calculator MMIO responder.
// Build option CALC_MMIO_ERRCNT_EN (see calc_mmio_responder) adds a protocol error counter.
package calc_mmio_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned MASK_W = 3;
    localparam int unsigned ERR_W  = 8;

    localparam logic [DATA_W-1:0] DONE_WORD      = 32'hFFFF_FFFF;
    localparam logic [DATA_W-1:0] TIMEOUT_RESULT = 32'hDEAD_0000;

    localparam logic [ADDR_W-1:0] OP1_ADDR_DEF    = 32'd220;
    localparam logic [ADDR_W-1:0] OP2_ADDR_DEF    = 32'd240;
    localparam logic [ADDR_W-1:0] OPSEL_ADDR_DEF  = 32'd260;
    localparam logic [ADDR_W-1:0] RESULT_ADDR_DEF = 32'd280;
    localparam logic [ADDR_W-1:0] IDLE_ADDR_DEF   = 32'd320;

    typedef enum logic [1:0] {
        COLLECT,
        COMPUTE,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        MB_OP1,
        MB_OP2,
        MB_OPSEL,
        MB_RESULT,
        MB_NONE
    } mbox_e;

    typedef struct packed {
        logic              en;
        mbox_e             sel;
        logic [DATA_W-1:0] data;
    } mbox_wr_t;

    // Map a bus address onto a mailbox; the idle address and anything unmapped give MB_NONE.
    function automatic mbox_e addr_decode(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] a_op1,
        input logic [ADDR_W-1:0] a_op2,
        input logic [ADDR_W-1:0] a_opsel,
        input logic [ADDR_W-1:0] a_result,
        input logic [ADDR_W-1:0] a_idle
    );
        if (addr == a_idle)        return MB_NONE;
        else if (addr == a_op1)    return MB_OP1;
        else if (addr == a_op2)    return MB_OP2;
        else if (addr == a_opsel)  return MB_OPSEL;
        else if (addr == a_result) return MB_RESULT;
        else                       return MB_NONE;
    endfunction

endpackage

// File: rtl/mmio_regfile.sv
// Four mailbox registers with operand valid bits, one write port and two registered read ports.
module mmio_regfile
    import calc_mmio_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  mbox_wr_t          wr,
    input  logic              clr_valid,
    input  logic              a_re,
    input  mbox_e             a_sel,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_re,
    input  mbox_e             b_sel,
    output logic [DATA_W-1:0] b_rdata,
    output logic [MASK_W-1:0] valid_mask
);

    logic [DATA_W-1:0] op1_q;
    logic [DATA_W-1:0] op2_q;
    logic [DATA_W-1:0] opsel_q;
    logic [DATA_W-1:0] result_q;
    logic [MASK_W-1:0] valid_set;
    logic [DATA_W-1:0] a_mux;
    logic [DATA_W-1:0] b_mux;

    function automatic logic [DATA_W-1:0] rd_mux(
        input mbox_e             sel,
        input logic [DATA_W-1:0] op1,
        input logic [DATA_W-1:0] op2,
        input logic [DATA_W-1:0] opsel,
        input logic [DATA_W-1:0] result
    );
        case (sel)
            MB_OP1:    return op1;
            MB_OP2:    return op2;
            MB_OPSEL:  return opsel;
            MB_RESULT: return result;
            default:   return '0;
        endcase
    endfunction

    // Valid bit ordering is {opsel, op2, op1}; the result mailbox has no valid bit.
    always_comb begin
        valid_set = '0;
        if (wr.en) begin
            case (wr.sel)
                MB_OP1:   valid_set[0] = 1'b1;
                MB_OP2:   valid_set[1] = 1'b1;
                MB_OPSEL: valid_set[2] = 1'b1;
                default:  valid_set    = '0;
            endcase
        end
    end

    always_comb begin
        a_mux = rd_mux(a_sel, op1_q, op2_q, opsel_q, result_q);
        b_mux = rd_mux(b_sel, op1_q, op2_q, opsel_q, result_q);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            op1_q      <= '0;
            op2_q      <= '0;
            opsel_q    <= '0;
            result_q   <= '0;
            valid_mask <= '0;
        end else begin
            if (wr.en) begin
                case (wr.sel)
                    MB_OP1:    op1_q    <= wr.data;
                    MB_OP2:    op2_q    <= wr.data;
                    MB_OPSEL:  opsel_q  <= wr.data;
                    MB_RESULT: result_q <= wr.data;
                    default:   ;
                endcase
            end
            // A clear and a write in the same cycle leave only the freshly written bit set.
            valid_mask <= (clr_valid ? '0 : valid_mask) | valid_set;
        end
    end

    // Read data holds between reads.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            if (a_re) a_rdata <= a_mux;
            if (b_re) b_rdata <= b_mux;
        end
    end

endmodule

// File: rtl/calc_mmio_responder.sv
// MMIO responder: front end fills operand mailboxes, CPU computes and posts the result, front end reads it.
// Define CALC_MMIO_ERRCNT_EN to add the saturating err_count output.
module calc_mmio_responder
    import calc_mmio_pkg::*;
#(
    parameter logic [ADDR_W-1:0] OP1_ADDR    = OP1_ADDR_DEF,
    parameter logic [ADDR_W-1:0] OP2_ADDR    = OP2_ADDR_DEF,
    parameter logic [ADDR_W-1:0] OPSEL_ADDR  = OPSEL_ADDR_DEF,
    parameter logic [ADDR_W-1:0] RESULT_ADDR = RESULT_ADDR_DEF,
    parameter logic [ADDR_W-1:0] IDLE_ADDR   = IDLE_ADDR_DEF,
    parameter int unsigned       TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              fpga_en,
    input  logic              fpga_write,
    input  logic [ADDR_W-1:0] fpga_addr,
    input  logic [DATA_W-1:0] fpga_wdata,
    output logic [DATA_W-1:0] fpga_rdata,
    input  logic              cpu_en,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] done_instr,
    output logic [MASK_W-1:0] valid_mask
`ifdef CALC_MMIO_ERRCNT_EN
    ,
    output logic [ERR_W-1:0]  err_count
`endif
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    mbox_e            fpga_sel;
    mbox_e            cpu_sel;
    mbox_e            fpga_rd_sel;
    mbox_wr_t         wr;
    logic             clr_valid;
    logic             cpu_rd_en;
    logic             fpga_rd_en;
    logic             fpga_wr_op;
    logic             cpu_result_wr;
    logic             timeout_hit;

    assign fpga_sel = addr_decode(fpga_addr, OP1_ADDR, OP2_ADDR, OPSEL_ADDR, RESULT_ADDR, IDLE_ADDR);
    assign cpu_sel  = addr_decode(cpu_addr, OP1_ADDR, OP2_ADDR, OPSEL_ADDR, RESULT_ADDR, IDLE_ADDR);

    // Front-end writes only ever land in the three operand mailboxes.
    assign fpga_wr_op    = fpga_en && fpga_write && (fpga_sel inside {MB_OP1, MB_OP2, MB_OPSEL});
    assign cpu_result_wr = cpu_write && (cpu_sel == MB_RESULT);
    assign timeout_hit   = (state_q == COMPUTE) && cpu_en && !cpu_result_wr && (cnt_q == CNT_LAST);

    // The CPU owns the bus only while in COMPUTE with the grant held.
    assign cpu_ack = (state_q == COMPUTE) && cpu_en && (cpu_read || cpu_write);

    always_comb begin
        state_d     = state_q;
        wr          = '{en: 1'b0, sel: MB_NONE, data: '0};
        clr_valid   = 1'b0;
        cpu_rd_en   = 1'b0;
        fpga_rd_en  = 1'b0;
        fpga_rd_sel = MB_NONE;
        case (state_q)
            COLLECT: begin
                if (fpga_wr_op) wr = '{en: 1'b1, sel: fpga_sel, data: fpga_wdata};
                if (cpu_en) state_d = COMPUTE;
            end
            COMPUTE: begin
                if (!cpu_en) begin
                    state_d = COLLECT;
                end else begin
                    cpu_rd_en = cpu_read && !cpu_write;
                    if (cpu_result_wr) begin
                        wr      = '{en: 1'b1, sel: MB_RESULT, data: cpu_wdata};
                        state_d = DONE;
                    end else if (timeout_hit) begin
                        wr      = '{en: 1'b1, sel: MB_RESULT, data: TIMEOUT_RESULT};
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (fpga_en && !fpga_write) begin
                    fpga_rd_en  = 1'b1;
                    fpga_rd_sel = (fpga_sel == MB_RESULT) ? MB_RESULT : MB_NONE;
                end
                // Any front-end write releases display and starts a fresh collection.
                if (fpga_en && fpga_write) begin
                    clr_valid = 1'b1;
                    state_d   = COLLECT;
                    if (fpga_wr_op) wr = '{en: 1'b1, sel: fpga_sel, data: fpga_wdata};
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= COLLECT;
            cnt_q      <= '0;
            done_instr <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= (state_q == COMPUTE && state_d == COMPUTE) ? cnt_q + CNT_W'(1) : '0;
            done_instr <= (state_q == DONE && state_d == DONE) ? DONE_WORD : '0;
        end
    end

    mmio_regfile u_regfile (
        .clk        (clk),
        .nrst       (nrst),
        .wr         (wr),
        .clr_valid  (clr_valid),
        .a_re       (cpu_rd_en),
        .a_sel      (cpu_sel),
        .a_rdata    (cpu_rdata),
        .b_re       (fpga_rd_en),
        .b_sel      (fpga_rd_sel),
        .b_rdata    (fpga_rdata),
        .valid_mask (valid_mask)
    );

`ifdef CALC_MMIO_ERRCNT_EN
    logic err_evt;

    // Protocol errors: front-end write while computing, CPU strobe without the bus, or a timeout.
    assign err_evt = ((state_q == COMPUTE) && fpga_en && fpga_write)
                  || ((state_q != COMPUTE) && (cpu_read || cpu_write))
                  || timeout_hit;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err_count <= '0;
        end else if (err_evt && (err_count != {ERR_W{1'b1}})) begin
            err_count <= err_count + ERR_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_calc_mmio_responder.sv
// Scenario bench for calc_mmio_responder (TIMEOUT shortened to 16); read data checked through a scoreboard queue.
module tb_calc_mmio_responder;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        fpga_en, fpga_write, cpu_en, cpu_read, cpu_write, cpu_ack;
    logic [31:0] fpga_addr, fpga_wdata, fpga_rdata;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, done_instr;
    logic [2:0]  valid_mask;
`ifdef CALC_MMIO_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int exp_err  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    logic [31:0] col_addr[6] = '{32'd220, 32'd260, 32'd240, 32'd220, 32'd320, 32'd300};
    logic [31:0] col_data[6] = '{32'h11, 32'h3, 32'h17, 32'h25, 32'hAA, 32'hBB};
    logic [2:0]  col_mask[6] = '{3'b001, 3'b101, 3'b111, 3'b111, 3'b111, 3'b111};
    logic [31:0] rd_addr[5]  = '{32'd280, 32'd300, 32'd260, 32'd240, 32'd220};
    logic [31:0] rd_exp[5]   = '{32'h0, 32'h0, 32'h3, 32'h17, 32'h25};

    always #5 clk = ~clk;

    calc_mmio_responder #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .fpga_en    (fpga_en),
        .fpga_write (fpga_write),
        .fpga_addr  (fpga_addr),
        .fpga_wdata (fpga_wdata),
        .fpga_rdata (fpga_rdata),
        .cpu_en     (cpu_en),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .done_instr (done_instr),
        .valid_mask (valid_mask)
`ifdef CALC_MMIO_ERRCNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        fpga_en = 1'b0; fpga_write = 1'b0; fpga_addr = '0; fpga_wdata = '0;
        cpu_en = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    task automatic test_reset();
        bus_idle();
        nrst = 1'b0;
        #3;
        n_checks++; if (fpga_rdata !== 32'h0) $display("FAIL reset_fpga_rdata got %h want 0", fpga_rdata); else n_pass++;
        n_checks++; if (cpu_rdata !== 32'h0) $display("FAIL reset_cpu_rdata got %h want 0", cpu_rdata); else n_pass++;
        n_checks++; if (cpu_ack !== 1'b0) $display("FAIL reset_cpu_ack got %b want 0", cpu_ack); else n_pass++;
        n_checks++; if (done_instr !== 32'h0) $display("FAIL reset_done_instr got %h want 0", done_instr); else n_pass++;
        n_checks++; if (valid_mask !== 3'b000) $display("FAIL reset_valid_mask got %b want 000", valid_mask); else n_pass++;
        step();
        nrst = 1'b1;
        step();
    endtask

    task automatic test_collect();
        for (int i = 0; i < 6; i++) begin
            fpga_en = 1'b1; fpga_write = 1'b1; fpga_addr = col_addr[i]; fpga_wdata = col_data[i];
            step();
            fpga_en = 1'b0; fpga_write = 1'b0;
            n_checks++;
            if (valid_mask !== col_mask[i])
                $display("FAIL collect_mask[%0d] got %b want %b", i, valid_mask, col_mask[i]);
            else n_pass++;
        end
        cpu_read = 1'b1; cpu_addr = 32'd220;
        #1;
        n_checks++; if (cpu_ack !== 1'b0) $display("FAIL collect_cpu_ack got %b want 0", cpu_ack); else n_pass++;
        step();
        cpu_read = 1'b0;
        exp_err++;
        n_checks++; if (cpu_rdata !== 32'h0) $display("FAIL collect_cpu_rdata got %h want 0", cpu_rdata); else n_pass++;
    endtask

    task automatic test_cpu_reads();
        cpu_en = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            cpu_read = 1'b1; cpu_addr = rd_addr[i];
            exp_q.push_back(rd_exp[i]);
            #1;
            n_checks++; if (cpu_ack !== 1'b1) $display("FAIL read_ack[%0d] got %b want 1", i, cpu_ack); else n_pass++;
            step();
            cpu_read = 1'b0;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (cpu_rdata !== exp_v) $display("FAIL read_data[%0d] got %h want %h", i, cpu_rdata, exp_v);
            else n_pass++;
        end
        // Simultaneous read and non-result write: acked, write ignored, read not performed.
        cpu_read = 1'b1; cpu_write = 1'b1; cpu_addr = 32'd240; cpu_wdata = 32'h77;
        #1;
        n_checks++; if (cpu_ack !== 1'b1) $display("FAIL rw_ack got %b want 1", cpu_ack); else n_pass++;
        step();
        cpu_read = 1'b0; cpu_write = 1'b0;
        n_checks++; if (cpu_rdata !== 32'h25) $display("FAIL rw_hold got %h want 25", cpu_rdata); else n_pass++;
        fpga_en = 1'b1; fpga_write = 1'b1; fpga_addr = 32'd220; fpga_wdata = 32'h99;
        step();
        fpga_en = 1'b0; fpga_write = 1'b0;
        exp_err++;
`ifdef CALC_MMIO_ERRCNT_EN
        n_checks++; if (err_count !== 8'(exp_err)) $display("FAIL err_after_fpga got %0d want %0d", err_count, exp_err); else n_pass++;
`endif
        for (int i = 0; i < 2; i++) begin
            cpu_read = 1'b1; cpu_addr = (i == 0) ? 32'd220 : 32'd240;
            exp_q.push_back((i == 0) ? 32'h25 : 32'h17);
            step();
            cpu_read = 1'b0;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (cpu_rdata !== exp_v) $display("FAIL compute_reread[%0d] got %h want %h", i, cpu_rdata, exp_v);
            else n_pass++;
        end
        cpu_write = 1'b1; cpu_addr = 32'd280; cpu_wdata = 32'h3C;
        #1;
        n_checks++; if (cpu_ack !== 1'b1) $display("FAIL result_ack got %b want 1", cpu_ack); else n_pass++;
        step();
        cpu_write = 1'b0;
        n_checks++; if (done_instr !== 32'h0) $display("FAIL done_entry got %h want 0", done_instr); else n_pass++;
        step();
        n_checks++; if (done_instr !== 32'hFFFF_FFFF) $display("FAIL done_word got %h want ffffffff", done_instr); else n_pass++;
    endtask

    task automatic test_done();
        cpu_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fpga_en = 1'b1; fpga_write = 1'b0; fpga_addr = (i == 0) ? 32'd220 : 32'd280;
            exp_q.push_back((i == 0) ? 32'h0 : 32'h3C);
            step();
            fpga_en = 1'b0;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (fpga_rdata !== exp_v) $display("FAIL done_fpga_read[%0d] got %h want %h", i, fpga_rdata, exp_v);
            else n_pass++;
        end
        cpu_read = 1'b1; cpu_addr = 32'd220;
        #1;
        n_checks++; if (cpu_ack !== 1'b0) $display("FAIL done_cpu_ack got %b want 0", cpu_ack); else n_pass++;
        step();
        cpu_read = 1'b0;
        exp_err++;
        n_checks++; if (fpga_rdata !== 32'h3C) $display("FAIL fpga_rdata_hold got %h want 3c", fpga_rdata); else n_pass++;
        fpga_en = 1'b1; fpga_write = 1'b1; fpga_addr = 32'd320; fpga_wdata = 32'h1;
        step();
        fpga_en = 1'b0; fpga_write = 1'b0;
        n_checks++; if (valid_mask !== 3'b000) $display("FAIL release_mask got %b want 000", valid_mask); else n_pass++;
        n_checks++; if (done_instr !== 32'h0) $display("FAIL release_done got %h want 0", done_instr); else n_pass++;
    endtask

    task automatic test_timeout();
        int k;
        cpu_en = 1'b1;
        step();
        cpu_read = 1'b1; cpu_addr = 32'd280;
        exp_q.push_back(32'h3C);
        step();
        cpu_read = 1'b0;
        exp_v = exp_q.pop_front();
        n_checks++; if (cpu_rdata !== exp_v) $display("FAIL result_kept got %h want %h", cpu_rdata, exp_v); else n_pass++;
        k = 1;
        while (done_instr === 32'h0 && k < 40) begin
            step();
            k++;
        end
        exp_err++;
        n_checks++; if (k !== 17) $display("FAIL timeout_cycle got %0d want 17", k); else n_pass++;
        cpu_en = 1'b0;
        fpga_en = 1'b1; fpga_write = 1'b0; fpga_addr = 32'd280;
        exp_q.push_back(32'hDEAD_0000);
        step();
        fpga_en = 1'b0;
        exp_v = exp_q.pop_front();
        n_checks++; if (fpga_rdata !== exp_v) $display("FAIL timeout_result got %h want %h", fpga_rdata, exp_v); else n_pass++;
    endtask

    task automatic test_abort();
        fpga_en = 1'b1; fpga_write = 1'b1; fpga_addr = 32'd220; fpga_wdata = 32'h5A;
        step();
        fpga_en = 1'b0; fpga_write = 1'b0;
        n_checks++; if (valid_mask !== 3'b001) $display("FAIL release_write_mask got %b want 001", valid_mask); else n_pass++;
        cpu_en = 1'b1;
        step();
        cpu_en = 1'b0;
        step();
        n_checks++; if (valid_mask !== 3'b001) $display("FAIL abort_mask got %b want 001", valid_mask); else n_pass++;
        cpu_read = 1'b1; cpu_addr = 32'd220;
        #1;
        n_checks++; if (cpu_ack !== 1'b0) $display("FAIL abort_cpu_ack got %b want 0", cpu_ack); else n_pass++;
        step();
        cpu_read = 1'b0;
        exp_err++;
`ifdef CALC_MMIO_ERRCNT_EN
        n_checks++; if (err_count !== 8'(exp_err)) $display("FAIL err_total got %0d want %0d", err_count, exp_err); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        cpu_en = 1'b1;
        step();
        cpu_read = 1'b1; cpu_addr = 32'd220;
        #1;
        n_checks++; if (cpu_ack !== 1'b1) $display("FAIL pre_reset_ack got %b want 1", cpu_ack); else n_pass++;
        #1;
        nrst = 1'b0;
        #1;
        n_checks++; if (cpu_ack !== 1'b0) $display("FAIL mid_reset_ack got %b want 0", cpu_ack); else n_pass++;
        n_checks++; if (cpu_rdata !== 32'h0) $display("FAIL mid_reset_cpu_rdata got %h want 0", cpu_rdata); else n_pass++;
        n_checks++; if (fpga_rdata !== 32'h0) $display("FAIL mid_reset_fpga_rdata got %h want 0", fpga_rdata); else n_pass++;
        n_checks++; if (valid_mask !== 3'b000) $display("FAIL mid_reset_mask got %b want 000", valid_mask); else n_pass++;
        exp_err = 0;
`ifdef CALC_MMIO_ERRCNT_EN
        n_checks++; if (err_count !== 8'd0) $display("FAIL mid_reset_err got %0d want 0", err_count); else n_pass++;
`endif
        bus_idle();
        step();
        nrst = 1'b1;
        step();
        cpu_read = 1'b1; cpu_addr = 32'd220;
        #1;
        n_checks++; if (cpu_ack !== 1'b0) $display("FAIL post_reset_collect_ack got %b want 0", cpu_ack); else n_pass++;
        step();
        cpu_read = 1'b0;
        exp_err++;
        cpu_en = 1'b1;
        step();
        cpu_read = 1'b1; cpu_addr = 32'd220;
        exp_q.push_back(32'h0);
        step();
        cpu_read = 1'b0;
        exp_v = exp_q.pop_front();
        n_checks++; if (cpu_rdata !== exp_v) $display("FAIL post_reset_op1 got %h want %h", cpu_rdata, exp_v); else n_pass++;
`ifdef CALC_MMIO_ERRCNT_EN
        n_checks++; if (err_count !== 8'(exp_err)) $display("FAIL post_reset_err got %0d want %0d", err_count, exp_err); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_collect();
        test_cpu_reads();
        test_done();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
